// File: rtl/inst_issue_queue_pkg.sv
// Shared types for the dual-write/dual-read instruction issue queue.
// Queue entry layout and the two-state flush/delay-slot FSM encoding.
package inst_issue_queue_pkg;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        excp;
    } iq_entry_t;

    typedef logic [0:0] iq_state_t;

    localparam iq_state_t IqRun    = 1'b0;
    localparam iq_state_t IqWaitDs = 1'b1;

endpackage

// File: rtl/inst_issue_queue_regfile.sv
// Entry storage for the issue queue: two write ports, two asynchronous read ports.
// Storage is intentionally not reset; the top masks fields of invalid slots.
module inst_issue_queue_regfile
    import inst_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = 4
) (
    input  logic             clk_i,
    input  logic             we0_i,
    input  logic [PTR_W-1:0] waddr0_i,
    input  iq_entry_t        wdata0_i,
    input  logic             we1_i,
    input  logic [PTR_W-1:0] waddr1_i,
    input  iq_entry_t        wdata1_i,
    input  logic [PTR_W-1:0] raddr0_i,
    input  logic [PTR_W-1:0] raddr1_i,
    output iq_entry_t        rdata0_o,
    output iq_entry_t        rdata1_o
);

    iq_entry_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we0_i) begin
            mem_q[waddr0_i] <= wdata0_i;
        end
        if (we1_i) begin
            mem_q[waddr1_i] <= wdata1_i;
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/inst_issue_queue.sv
// Dual-write/dual-read instruction queue between fetch and dual-issue decode, with branch flush
// and delay-slot retention. Define INST_ISSUE_QUEUE_STATS_EN to add the perf counter outputs.
module inst_issue_queue
    import inst_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       in_valid_i,
    input  logic [31:0]      in_inst0_i,
    input  logic [31:0]      in_inst1_i,
    input  logic [31:0]      in_pc0_i,
    input  logic [31:0]      in_pc1_i,
    input  logic             in_excp0_i,
    input  logic             in_excp1_i,
    output logic             in_ready_o,
    input  logic             pop_master_i,
    input  logic             pop_slave_i,
    input  logic             flush_i,
    input  logic             flush_keep_ds_i,
    output logic             out0_valid_o,
    output logic [31:0]      out0_inst_o,
    output logic [31:0]      out0_pc_o,
    output logic             out0_excp_o,
    output logic             out1_valid_o,
    output logic [31:0]      out1_inst_o,
    output logic [31:0]      out1_pc_o,
    output logic             out1_excp_o,
    output logic             fifo_empty_o,
    output logic             fifo_almost_empty_o,
    output logic [PTR_W:0]   count_o
`ifdef INST_ISSUE_QUEUE_STATS_EN
    ,
    output logic [31:0]      perf_empty_cycles_o,
    output logic [31:0]      perf_dual_pops_o
`endif
);

    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] ReadyMax = CNT_W'(DEPTH - 2);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    iq_state_t        state_q, state_d;

    logic             push_acc, push_two;
    logic [1:0]       push_n, pop_n;
    logic             pop_m, pop_s;
    logic [PTR_W-1:0] rd_adv;
    logic             we0, we1;
    iq_entry_t        wdata0, wdata1, rdata0, rdata1;

    assign wdata0 = '{inst: in_inst0_i, pc: in_pc0_i, excp: in_excp0_i};
    assign wdata1 = '{inst: in_inst1_i, pc: in_pc1_i, excp: in_excp1_i};

    // Push/pop clamping; 2'b10 is an illegal fetch pattern and is ignored.
    always_comb begin
        in_ready_o = (count_q <= ReadyMax);
        push_acc   = in_ready_o && (in_valid_i == 2'b01 || in_valid_i == 2'b11);
        push_two   = in_ready_o && (in_valid_i == 2'b11);
        push_n     = {push_two, push_acc && !push_two};
        pop_m      = pop_master_i && (count_q != '0);
        pop_s      = pop_slave_i && pop_master_i && (count_q >= CNT_W'(2));
        pop_n      = {1'b0, pop_m} + {1'b0, pop_s};
        rd_adv     = rd_ptr_q + PTR_W'(pop_n);
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        we0      = 1'b0;
        we1      = 1'b0;
        if (flush_i && !flush_keep_ds_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            state_d  = IqRun;
        end else if (flush_i) begin
            // Survivor (if any) stays in place at rd_ptr+pop_n; when nothing survives,
            // rd_adv equals wr_ptr so a delay slot arriving now or later lands there.
            rd_ptr_d = rd_adv;
            state_d  = IqRun;
            if (count_q > CNT_W'(pop_n)) begin
                wr_ptr_d = rd_adv + PTR_W'(1);
                count_d  = CNT_W'(1);
            end else if (push_acc) begin
                we0      = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                count_d  = CNT_W'(1);
            end else begin
                count_d  = '0;
                state_d  = IqWaitDs;
            end
        end else if (state_q == IqWaitDs) begin
            if (push_acc) begin
                we0      = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                count_d  = CNT_W'(1);
                state_d  = IqRun;
            end
        end else begin
            rd_ptr_d = rd_adv;
            we0      = push_acc;
            we1      = push_two;
            wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
            count_d  = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IqRun;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
        end
    end

    inst_issue_queue_regfile #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_regfile (
        .clk_i    (clk_i),
        .we0_i    (we0),
        .waddr0_i (wr_ptr_q),
        .wdata0_i (wdata0),
        .we1_i    (we1),
        .waddr1_i (wr_ptr_q + PTR_W'(1)),
        .wdata1_i (wdata1),
        .raddr0_i (rd_ptr_q),
        .raddr1_i (rd_ptr_q + PTR_W'(1)),
        .rdata0_o (rdata0),
        .rdata1_o (rdata1)
    );

    always_comb begin
        out0_valid_o        = (count_q != '0);
        out1_valid_o        = (count_q >= CNT_W'(2));
        out0_inst_o         = out0_valid_o ? rdata0.inst : '0;
        out0_pc_o           = out0_valid_o ? rdata0.pc   : '0;
        out0_excp_o         = out0_valid_o && rdata0.excp;
        out1_inst_o         = out1_valid_o ? rdata1.inst : '0;
        out1_pc_o           = out1_valid_o ? rdata1.pc   : '0;
        out1_excp_o         = out1_valid_o && rdata1.excp;
        fifo_empty_o        = (count_q == '0);
        fifo_almost_empty_o = (count_q == CNT_W'(1));
        count_o             = count_q;
    end

    illegal_pop_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !((pop_master_i && count_q == '0) ||
          (pop_slave_i && !(pop_master_i && count_q >= CNT_W'(2)))))
        else $warning("inst_issue_queue: illegal pop request clamped");

`ifdef INST_ISSUE_QUEUE_STATS_EN
    logic [31:0] perf_empty_q, perf_dual_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_empty_q <= '0;
            perf_dual_q  <= '0;
        end else begin
            if (count_q == '0 && state_q == IqRun && perf_empty_q != '1) begin
                perf_empty_q <= perf_empty_q + 32'd1;
            end
            if (pop_n == 2'd2 && perf_dual_q != '1) begin
                perf_dual_q <= perf_dual_q + 32'd1;
            end
        end
    end

    assign perf_empty_cycles_o = perf_empty_q;
    assign perf_dual_pops_o    = perf_dual_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_inst_issue_queue.sv
// Self-checking bench for inst_issue_queue: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the occupancy/flush rules.
module tb_inst_issue_queue;

    localparam int unsigned DEPTH = 16;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        excp;
    } ent_t;

    logic        clk, rst;
    logic [1:0]  in_valid;
    logic [31:0] in_inst0, in_inst1, in_pc0, in_pc1;
    logic        in_excp0, in_excp1;
    logic        in_ready;
    logic        pop_master, pop_slave, flush, flush_keep_ds;
    logic        out0_valid, out0_excp, out1_valid, out1_excp;
    logic [31:0] out0_inst, out0_pc, out1_inst, out1_pc;
    logic        fifo_empty, fifo_almost_empty;
    logic [4:0]  count;
`ifdef INST_ISSUE_QUEUE_STATS_EN
    logic [31:0] perf_empty_cycles, perf_dual_pops;
`endif

    int   n_checks = 0;
    int   n_pass   = 0;
    ent_t mq[$];
    bit   m_wait;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    inst_issue_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .in_valid_i          (in_valid),
        .in_inst0_i          (in_inst0),
        .in_inst1_i          (in_inst1),
        .in_pc0_i            (in_pc0),
        .in_pc1_i            (in_pc1),
        .in_excp0_i          (in_excp0),
        .in_excp1_i          (in_excp1),
        .in_ready_o          (in_ready),
        .pop_master_i        (pop_master),
        .pop_slave_i         (pop_slave),
        .flush_i             (flush),
        .flush_keep_ds_i     (flush_keep_ds),
        .out0_valid_o        (out0_valid),
        .out0_inst_o         (out0_inst),
        .out0_pc_o           (out0_pc),
        .out0_excp_o         (out0_excp),
        .out1_valid_o        (out1_valid),
        .out1_inst_o         (out1_inst),
        .out1_pc_o           (out1_pc),
        .out1_excp_o         (out1_excp),
        .fifo_empty_o        (fifo_empty),
        .fifo_almost_empty_o (fifo_almost_empty),
        .count_o             (count)
`ifdef INST_ISSUE_QUEUE_STATS_EN
        ,
        .perf_empty_cycles_o (perf_empty_cycles),
        .perf_dual_pops_o    (perf_dual_pops)
`endif
    );

    task automatic drive_idle();
        in_valid      = 2'b00;
        in_inst0      = '0;
        in_inst1      = '0;
        in_pc0        = '0;
        in_pc1        = '0;
        in_excp0      = 1'b0;
        in_excp1      = 1'b0;
        pop_master    = 1'b0;
        pop_slave     = 1'b0;
        flush         = 1'b0;
        flush_keep_ds = 1'b0;
    endtask

    task automatic set_push(input logic [1:0] v, input logic [31:0] pc0);
        in_valid = v;
        in_pc0   = pc0;
        in_pc1   = pc0 + 32'd4;
        in_inst0 = $urandom();
        in_inst1 = $urandom();
        in_excp0 = 1'($urandom_range(0, 1));
        in_excp1 = 1'($urandom_range(0, 1));
    endtask

    // Apply current inputs for one clock edge and advance the reference model.
    task automatic step();
        ent_t pushes[$];
        ent_t e0, e1;
        int   sz, pop_n;
        bit   ready, fl, keep;
        e0    = {in_inst0, in_pc0, in_excp0};
        e1    = {in_inst1, in_pc1, in_excp1};
        sz    = mq.size();
        ready = (sz <= DEPTH - 2);
        pop_n = 0;
        if (pop_master && sz > 0) pop_n = 1;
        if (pop_n == 1 && pop_slave && sz >= 2) pop_n = 2;
        if (ready && in_valid == 2'b01) pushes.push_back(e0);
        if (ready && in_valid == 2'b11) begin
            pushes.push_back(e0);
            pushes.push_back(e1);
        end
        fl   = flush;
        keep = flush_keep_ds;
        @(posedge clk);
        #1;
        if (fl && !keep) begin
            mq.delete();
            m_wait = 1'b0;
        end else begin
            repeat (pop_n) void'(mq.pop_front());
            if (fl) begin
                if (mq.size() >= 1) begin
                    ent_t k;
                    k = mq[0];
                    mq.delete();
                    mq.push_back(k);
                    m_wait = 1'b0;
                end else if (pushes.size() > 0) begin
                    mq.push_back(pushes[0]);
                    m_wait = 1'b0;
                end else begin
                    m_wait = 1'b1;
                end
            end else if (m_wait) begin
                if (pushes.size() > 0) begin
                    mq.push_back(pushes[0]);
                    m_wait = 1'b0;
                end
            end else begin
                foreach (pushes[i]) mq.push_back(pushes[i]);
            end
        end
        drive_idle();
    endtask

    task automatic clear_queue();
        flush = 1'b1;
        step();
    endtask

    task automatic test_reset();
        n_checks++; if (count !== 5'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
        n_checks++; if (fifo_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", fifo_empty); else n_pass++;
        n_checks++; if (fifo_almost_empty !== 1'b0) $display("FAIL reset_almost: got %b want 0", fifo_almost_empty); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else n_pass++;
        n_checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0)
            $display("FAIL reset_valid: got %b%b want 00", out0_valid, out1_valid); else n_pass++;
        n_checks++; if ({out0_inst, out0_pc, out0_excp, out1_inst, out1_pc, out1_excp} !== '0)
            $display("FAIL reset_data: got %h/%h want 0", out0_pc, out1_pc); else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (in_ready !== (mq.size() <= DEPTH - 2))
                $display("FAIL fill_ready: cycle %0d got %b want %b", i, in_ready, mq.size() <= DEPTH - 2);
            else n_pass++;
            set_push(2'b11, 32'h1000_0000 + 32'(i * 8));
            step();
        end
        n_checks++; if (count !== 5'd16) $display("FAIL fill_count: got %0d want 16", count); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL fill_ready_full: got %b want 0", in_ready); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (out0_pc !== 32'h1000_0000 + 32'(i * 8) || out1_pc !== 32'h1000_0004 + 32'(i * 8))
                $display("FAIL fill_order: got %h/%h want %h", out0_pc, out1_pc, 32'h1000_0000 + 32'(i * 8));
            else n_pass++;
            pop_master = 1'b1;
            pop_slave  = 1'b1;
            step();
        end
        n_checks++; if (fifo_empty !== 1'b1) $display("FAIL fill_drain_empty: got %b want 1", fifo_empty); else n_pass++;
    endtask

    task automatic test_illegal_pop();
        set_push(2'b01, 32'h0000_0040);
        step();
        n_checks++; if (fifo_almost_empty !== 1'b1) $display("FAIL ipop_almost: got %b want 1", fifo_almost_empty); else n_pass++;
        pop_master = 1'b1;
        pop_slave  = 1'b1;
        step();
        n_checks++; if (count !== 5'd0) $display("FAIL ipop_count: got %0d want 0", count); else n_pass++;
        n_checks++; if (fifo_empty !== 1'b1) $display("FAIL ipop_empty: got %b want 1", fifo_empty); else n_pass++;
        pop_master = 1'b1;
        step();
        n_checks++; if (count !== 5'd0) $display("FAIL ipop_underflow: got %0d want 0", count); else n_pass++;
    endtask

    task automatic test_push_pop_same();
        clear_queue();
        set_push(2'b11, 32'h0000_2000); step();
        set_push(2'b11, 32'h0000_2008); step();
        set_push(2'b01, 32'h0000_2010); step();
        n_checks++; if (count !== 5'd5) $display("FAIL pp_setup_count: got %0d want 5", count); else n_pass++;
        set_push(2'b11, 32'h0000_2018);
        pop_master = 1'b1;
        pop_slave  = 1'b1;
        step();
        n_checks++; if (count !== 5'd5) $display("FAIL pp_count: got %0d want 5", count); else n_pass++;
        n_checks++; if (out0_pc !== 32'h0000_2008 || out1_pc !== 32'h0000_200c)
            $display("FAIL pp_head: got %h/%h want 2008/200c", out0_pc, out1_pc); else n_pass++;
    endtask

    task automatic test_flush_keep();
        clear_queue();
        set_push(2'b11, 32'h0000_0200); step();
        set_push(2'b01, 32'h0000_0208); step();
        flush = 1'b1; flush_keep_ds = 1'b1; pop_master = 1'b1;
        set_push(2'b11, 32'h0000_0700);
        step();
        n_checks++; if (count !== 5'd1) $display("FAIL fk_count: got %0d want 1", count); else n_pass++;
        n_checks++; if (out0_pc !== 32'h0000_0204 || out1_valid !== 1'b0)
            $display("FAIL fk_head: got %h v1=%b want 204 v1=0", out0_pc, out1_valid); else n_pass++;
        set_push(2'b11, 32'h0000_0300); step();
        n_checks++; if (count !== 5'd3) $display("FAIL fk_run_count: got %0d want 3", count); else n_pass++;
    endtask

    task automatic test_wait_ds();
        clear_queue();
        set_push(2'b01, 32'h0000_0400); step();
        flush = 1'b1; flush_keep_ds = 1'b1; pop_master = 1'b1;
        step();
        n_checks++; if (count !== 5'd0 || fifo_empty !== 1'b1)
            $display("FAIL wd_enter: got count %0d empty %b want 0/1", count, fifo_empty); else n_pass++;
        set_push(2'b11, 32'h0000_0100); step();
        n_checks++; if (count !== 5'd1) $display("FAIL wd_count: got %0d want 1", count); else n_pass++;
        n_checks++; if (out0_pc !== 32'h0000_0100) $display("FAIL wd_pc: got %h want 100", out0_pc); else n_pass++;
        set_push(2'b11, 32'h0000_0500); step();
        n_checks++; if (count !== 5'd3) $display("FAIL wd_run_count: got %0d want 3", count); else n_pass++;
    endtask

    task automatic test_wrap();
        clear_queue();
        set_push(2'b11, 32'h0000_1000); step();
        for (int i = 0; i < 40; i++) begin
            n_checks++;
            if (count !== 5'd2 || out0_pc !== 32'h0000_1000 + 32'(4 * i))
                $display("FAIL wrap: cycle %0d got count %0d pc %h want 2 pc %h", i, count, out0_pc,
                         32'h0000_1000 + 32'(4 * i));
            else n_pass++;
            set_push(2'b01, 32'h0000_1008 + 32'(4 * i));
            pop_master = 1'b1;
            step();
        end
    endtask

    task automatic test_reset_mid();
        set_push(2'b11, 32'h0000_3000); step();
        set_push(2'b11, 32'h0000_3008); step();
        #2 rst = 1'b1;
        #1;
        n_checks++; if (count !== 5'd0 || out0_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL mid_reset: got count %0d v0 %b rdy %b want 0/0/1", count, out0_valid, in_ready);
        else n_pass++;
        #2 rst = 1'b0;
        mq.delete();
        m_wait = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (fifo_empty !== 1'b1) $display("FAIL mid_reset_empty: got %b want 1", fifo_empty); else n_pass++;
    endtask

    task automatic test_random();
        logic [139:0] got, exp;
        ent_t         e0, e1;
        int           sz;
        for (int i = 0; i < 400; i++) begin
            sz  = mq.size();
            e0  = (sz > 0) ? mq[0] : '0;
            e1  = (sz > 1) ? mq[1] : '0;
            exp = {5'(sz), sz <= DEPTH - 2, sz == 0, sz == 1, sz > 0, e0, sz > 1, e1};
            got = {count, in_ready, fifo_empty, fifo_almost_empty, out0_valid, out0_inst, out0_pc,
                   out0_excp, out1_valid, out1_inst, out1_pc, out1_excp};
            n_checks++;
            if (got !== exp) $display("FAIL random: cycle %0d got %h want %h", i, got, exp);
            else n_pass++;
            case ($urandom_range(0, 3))
                0: set_push(2'b00, 32'(i * 16));
                1: set_push(2'b01, 32'(i * 16));
                2: set_push(2'b11, 32'(i * 16));
                default: set_push(2'b10, 32'(i * 16));
            endcase
            pop_master = (sz > 0) && ($urandom_range(0, 2) != 0);
            pop_slave  = pop_master && (sz >= 2) && ($urandom_range(0, 1) != 0);
            if ($urandom_range(0, 19) == 0) begin
                flush         = 1'b1;
                flush_keep_ds = 1'($urandom_range(0, 1));
            end
            step();
        end
    endtask

    initial begin
        rst    = 1'b1;
        m_wait = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        test_reset();
        test_fill();
        test_illegal_pop();
        test_push_pop_same();
        test_flush_keep();
        test_wait_ds();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
